// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI data-island packet scheduler.
//   HB0_*        : packet-type header byte codes
//   grant_e      : which source won a data-island slot
//   pkt_hdr_t    : registered header/sample fields presented to the packet assembler
//   hb0_of()     : grant class -> HB0 code
//   present_of() : sample count (0..4) -> subpacket present mask
package hdmi_pkg;

    localparam logic [7:0] HB0_NULL  = 8'h00;
    localparam logic [7:0] HB0_ACR   = 8'h01;
    localparam logic [7:0] HB0_AUDIO = 8'h02;
    localparam logic [7:0] HB0_AVI   = 8'h82;
    localparam logic [7:0] HB0_AIF   = 8'h84;

    // One audio sample packet carries at most four subpackets.
    localparam int unsigned MAX_SAMPLES = 4;

    typedef enum logic [2:0] {
        GNT_NULL,
        GNT_ACR,
        GNT_AUDIO,
        GNT_AVI,
        GNT_AIF
    } grant_e;

    typedef struct packed {
        logic [7:0] ptype;
        logic [2:0] count;
        logic [3:0] present;
    } pkt_hdr_t;

    function automatic logic [7:0] hb0_of(input grant_e gnt);
        logic [7:0] code;
        case (gnt)
            GNT_ACR:   code = HB0_ACR;
            GNT_AUDIO: code = HB0_AUDIO;
            GNT_AVI:   code = HB0_AVI;
            GNT_AIF:   code = HB0_AIF;
            default:   code = HB0_NULL;
        endcase
        return code;
    endfunction

    // (1 << n) - 1, computed one bit wider so n = 4 yields 4'hF.
    function automatic logic [3:0] present_of(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/hdmi_acr_timer.sv
// Free-running audio clock regeneration period counter.
//   clk_pixel : pixel clock
//   reset     : synchronous, active-high; counter returns to 0
//   tick_c    : combinational, high for the one cycle in which the counter wraps
module hdmi_acr_timer #(
    parameter int unsigned PERIOD = 74250
) (
    input  logic clk_pixel,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick_c = (count_q == CNT_W'(PERIOD - 1));

    // Wrap from PERIOD-1 back to 0.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (tick_c) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Chooses which data-island packet is emitted in each announced island slot.
//   clk_pixel      : pixel clock, only clock
//   reset          : synchronous, active-high
//   audio_strobe   : one pulse per new stereo sample
//   frame_start    : one pulse at first pixel of each frame; requests AVI + audio InfoFrames
//   slot_open      : one pulse, a data-island slot begins now
//   packet_valid   : one-cycle pulse one cycle after an accepted slot_open
//   packet_type    : HB0 of the granted packet, held until the next grant
//   sample_count   : samples carried by an audio packet, else 0
//   sample_present : subpacket present mask for sample_count
//   overflow       : sticky, a sample arrived with the pending counter full
//   slot_collision : sticky, slot_open arrived while the previous packet was still busy
module hdmi_packet_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned ACR_PERIOD_CYCLES = 74250,
    parameter int unsigned PENDING_DEPTH     = 8,
    parameter int unsigned SLOT_CYCLES       = 32
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       audio_strobe,
    input  logic       frame_start,
    input  logic       slot_open,
    output logic       packet_valid,
    output logic [7:0] packet_type,
    output logic [2:0] sample_count,
    output logic [3:0] sample_present,
    output logic       overflow,
    output logic       slot_collision
);

    localparam int unsigned PEND_W = $clog2(PENDING_DEPTH + 1);
    localparam int unsigned BUSY_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              acr_pend_q, acr_pend_d;
    logic              avi_pend_q, avi_pend_d;
    logic              aif_pend_q, aif_pend_d;
    logic [BUSY_W-1:0] busy_q, busy_d;
    logic              valid_q, valid_d;
    pkt_hdr_t          hdr_q, hdr_d;
    logic              overflow_q, overflow_d;
    logic              collision_q, collision_d;

    logic              acr_tick_c;
    grant_e            gnt_c;
    logic [2:0]        audio_cnt_c;
    logic [2:0]        grant_cnt_c;
    logic              accept_c;

    hdmi_acr_timer #(
        .PERIOD (ACR_PERIOD_CYCLES)
    ) u_acr_timer (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .tick_c    (acr_tick_c)
    );

    // Fixed-priority arbiter; a deep audio backlog pre-empts ACR to avoid starvation.
    function automatic grant_e arbitrate(
        input logic [PEND_W-1:0] pend,
        input logic              acr,
        input logic              avi,
        input logic              aif
    );
        grant_e g;
        if (pend >= PEND_W'(MAX_SAMPLES)) begin
            g = GNT_AUDIO;
        end else if (acr) begin
            g = GNT_ACR;
        end else if (pend != '0) begin
            g = GNT_AUDIO;
        end else if (avi) begin
            g = GNT_AVI;
        end else if (aif) begin
            g = GNT_AIF;
        end else begin
            g = GNT_NULL;
        end
        return g;
    endfunction

    assign gnt_c       = arbitrate(pending_q, acr_pend_q, avi_pend_q, aif_pend_q);
    assign audio_cnt_c = (pending_q >= PEND_W'(MAX_SAMPLES)) ? 3'(MAX_SAMPLES) : 3'(pending_q);
    assign accept_c    = slot_open && (busy_q == '0);
    assign grant_cnt_c = (accept_c && (gnt_c == GNT_AUDIO)) ? audio_cnt_c : 3'd0;

    // Next-state logic for the flags, counters and output stage.
    always_comb begin
        pending_d   = pending_q;
        acr_pend_d  = acr_pend_q;
        avi_pend_d  = avi_pend_q;
        aif_pend_d  = aif_pend_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        hdr_d       = hdr_q;
        overflow_d  = overflow_q;
        collision_d = collision_q;

        if (busy_q != '0) begin
            busy_d = busy_q - BUSY_W'(1);
        end

        if (slot_open && !accept_c) begin
            collision_d = 1'b1;
        end

        if (accept_c) begin
            valid_d       = 1'b1;
            busy_d        = BUSY_W'(SLOT_CYCLES - 1);
            hdr_d.ptype   = hb0_of(gnt_c);
            hdr_d.count   = grant_cnt_c;
            hdr_d.present = present_of(grant_cnt_c);
            case (gnt_c)
                GNT_ACR: acr_pend_d = 1'b0;
                GNT_AVI: avi_pend_d = 1'b0;
                GNT_AIF: aif_pend_d = 1'b0;
                default: ;
            endcase
        end

        // A sample arriving at full with nothing drained is lost; otherwise net the update.
        if (audio_strobe && (pending_q == PEND_W'(PENDING_DEPTH)) && (grant_cnt_c == 3'd0)) begin
            overflow_d = 1'b1;
        end else begin
            pending_d = pending_q + PEND_W'(audio_strobe) - PEND_W'(grant_cnt_c);
        end

        // New requests win over a same-cycle grant clear.
        if (acr_tick_c) begin
            acr_pend_d = 1'b1;
        end
        if (frame_start) begin
            avi_pend_d = 1'b1;
            aif_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pending_q   <= '0;
            acr_pend_q  <= 1'b0;
            avi_pend_q  <= 1'b1;
            aif_pend_q  <= 1'b1;
            busy_q      <= '0;
            valid_q     <= 1'b0;
            hdr_q       <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            acr_pend_q  <= acr_pend_d;
            avi_pend_q  <= avi_pend_d;
            aif_pend_q  <= aif_pend_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            hdr_q       <= hdr_d;
            overflow_q  <= overflow_d;
            collision_q <= collision_d;
        end
    end

    assign packet_valid   = valid_q;
    assign packet_type    = hdr_q.ptype;
    assign sample_count   = hdr_q.count;
    assign sample_present = hdr_q.present;
    assign overflow       = overflow_q;
    assign slot_collision = collision_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Self-checking bench for hdmi_packet_scheduler: a cycle model predicts each grant,
// pushes it to a scoreboard queue, and the queue is popped when packet_valid pulses.
module tb_hdmi_packet_scheduler;

    localparam int unsigned ACR_P = 100;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLOT  = 32;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       audio_strobe;
    logic       frame_start;
    logic       slot_open;
    logic       packet_valid;
    logic [7:0] packet_type;
    logic [2:0] sample_count;
    logic [3:0] sample_present;
    logic       overflow;
    logic       slot_collision;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_scheduler #(
        .ACR_PERIOD_CYCLES (ACR_P),
        .PENDING_DEPTH     (DEPTH),
        .SLOT_CYCLES       (SLOT)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .audio_strobe   (audio_strobe),
        .frame_start    (frame_start),
        .slot_open      (slot_open),
        .packet_valid   (packet_valid),
        .packet_type    (packet_type),
        .sample_count   (sample_count),
        .sample_present (sample_present),
        .overflow       (overflow),
        .slot_collision (slot_collision)
    );

    typedef struct {
        logic [7:0] ptype;
        logic [2:0] count;
        logic [3:0] present;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] present_lut [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_pend, m_timer, m_busy, m_cnt;
    bit         m_acr, m_avi, m_aif, m_ovf, m_coll, m_valid;
    logic [7:0] m_type;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit rst, input bit st, input bit fs, input bit so);
        bit         tick;
        bit         g;
        int         n;
        logic [7:0] t;
        if (rst) begin
            m_pend = 0; m_timer = 0; m_busy = 0; m_cnt = 0;
            m_acr = 0; m_avi = 1; m_aif = 1; m_ovf = 0; m_coll = 0; m_valid = 0;
            m_type = 8'h00;
            return;
        end
        tick    = (m_timer == int'(ACR_P) - 1);
        g       = so && (m_busy == 0);
        n       = 0;
        m_valid = 0;
        if (so && !g) m_coll = 1;
        if (m_busy > 0) m_busy--;
        if (g) begin
            if (m_pend >= 4)      begin t = 8'h02; n = 4; end
            else if (m_acr)       begin t = 8'h01; m_acr = 0; end
            else if (m_pend > 0)  begin t = 8'h02; n = m_pend; end
            else if (m_avi)       begin t = 8'h82; m_avi = 0; end
            else if (m_aif)       begin t = 8'h84; m_aif = 0; end
            else                  t = 8'h00;
            m_valid = 1;
            m_type  = t;
            m_cnt   = n;
            m_busy  = int'(SLOT) - 1;
            sb_q.push_back('{t, 3'(n), present_lut[n]});
        end
        if (st && m_pend == int'(DEPTH) && n == 0) m_ovf = 1;
        else m_pend = m_pend + (st ? 1 : 0) - n;
        if (tick) begin m_timer = 0; m_acr = 1; end
        else m_timer++;
        if (fs) begin m_avi = 1; m_aif = 1; end
    endtask

    task automatic compare_outputs();
        exp_t e;
        check_eq("valid", 32'(packet_valid), 32'(m_valid));
        if (packet_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_type",    32'(packet_type),    32'(e.ptype));
            check_eq("sb_count",   32'(sample_count),   32'(e.count));
            check_eq("sb_present", 32'(sample_present), 32'(e.present));
        end
        sb_q.delete();
        check_eq("type_hold",    32'(packet_type),    32'(m_type));
        check_eq("count_hold",   32'(sample_count),   32'(m_cnt));
        check_eq("present_hold", 32'(sample_present), 32'(present_lut[m_cnt]));
        check_eq("overflow",     32'(overflow),       32'(m_ovf));
        check_eq("collision",    32'(slot_collision), 32'(m_coll));
    endtask

    task automatic step(input bit rst, input bit st, input bit fs, input bit so);
        reset        = rst;
        audio_strobe = st;
        frame_start  = fs;
        slot_open    = so;
        model_step(rst, st, fs, so);
        @(posedge clk_pixel);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("rst_valid", 32'({packet_valid, packet_type, sample_count, sample_present}), 32'(0));
        check_eq("rst_flags", 32'({overflow, slot_collision}), 32'(0));
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    // Directed slot with the packet expected straight from the packet rules.
    task automatic slot_expect(input string tag, input bit st, input bit fs,
                               input logic [7:0] t, input logic [2:0] c);
        step(0, st, fs, 1);
        check_eq(tag, 32'({packet_valid, packet_type, sample_count}), 32'({1'b1, t, c}));
    endtask

    initial begin
        // 1: InfoFrames pending from reset, then null
        do_reset();
        idle(5);
        slot_expect("t1_avi", 0, 0, 8'h82, 3'd0);
        idle(31);
        slot_expect("t1_aif", 0, 0, 8'h84, 3'd0);
        idle(31);
        slot_expect("t1_null", 0, 0, 8'h00, 3'd0);

        // 2: three samples drained in one packet
        do_reset();
        strobes(3);
        idle(2);
        slot_expect("t2_audio3", 0, 0, 8'h02, 3'd3);
        check_eq("t2_present", 32'(sample_present), 32'(4'b0111));
        idle(31);
        slot_expect("t2_drained", 0, 0, 8'h82, 3'd0);

        // 3: ACR beats a small audio backlog
        do_reset();
        strobes(2);
        idle(100);
        slot_expect("t3_acr", 0, 0, 8'h01, 3'd0);
        idle(31);
        slot_expect("t3_audio2", 0, 0, 8'h02, 3'd2);

        // 4: starvation guard beats ACR
        do_reset();
        strobes(6);
        idle(100);
        slot_expect("t4_audio4", 0, 0, 8'h02, 3'd4);
        idle(31);
        slot_expect("t4_acr", 0, 0, 8'h01, 3'd0);
        idle(31);
        slot_expect("t4_audio2", 0, 0, 8'h02, 3'd2);

        // 5: saturation, overflow, strobe coincident with grant
        do_reset();
        strobes(9);
        check_eq("t5_overflow", 32'(overflow), 32'(1));
        slot_expect("t5_grant_strobe", 1, 0, 8'h02, 3'd4);
        idle(31);
        slot_expect("t5_pend5", 0, 0, 8'h02, 3'd4);
        idle(31);
        slot_expect("t5_pend1", 0, 0, 8'h02, 3'd1);
        check_eq("t5_ovf_sticky", 32'(overflow), 32'(1));

        // 6: busy window, boundary acceptance, frame_start vs AVI grant
        do_reset();
        idle(5);
        slot_expect("t6_avi", 0, 0, 8'h82, 3'd0);
        idle(9);
        step(0, 0, 0, 1);
        check_eq("t6_ignored", 32'({packet_valid, slot_collision}), 32'({1'b0, 1'b1}));
        idle(21);
        slot_expect("t6_boundary", 0, 0, 8'h84, 3'd0);
        do_reset();
        idle(5);
        slot_expect("t6_avi_fs", 0, 1, 8'h82, 3'd0);
        idle(31);
        slot_expect("t6_avi_again", 0, 0, 8'h82, 3'd0);

        // Random traffic against the model, including mid-operation resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(999) == 0),
                 ($urandom_range(9) == 0),
                 ($urandom_range(399) == 0),
                 ($urandom_range(24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
